// File: rtl/alu_uart_ctrl_if.sv
// alu_uart_ctrl_if
// Bus between the ALU/UART frame controller and its environment.
//   master : the controller side. It receives the UART rx/tx handshakes and the ALU
//            result, and drives the operands, the opcode, the tx request and the status flags.
//   slave  : the environment side, made up of the UART receiver, transmitter and ALU.
// Signal names follow the controller's external pin names.
interface alu_uart_ctrl_if #(
  parameter int MAXTAM = 8,
  parameter int tam_OP = 6
);
  logic              rx_done;
  logic [MAXTAM-1:0] rx_data;
  logic [MAXTAM-1:0] alu_result;
  logic              tx_busy;
  logic              tx_done;
  logic [MAXTAM-1:0] A;
  logic [MAXTAM-1:0] B;
  logic [tam_OP-1:0] OP;
  logic              tx_start;
  logic [MAXTAM-1:0] tx_data;
  logic              busy;
  logic              err_timeout;
  logic              err_overrun;

  modport master (
    input  rx_done, rx_data, alu_result, tx_busy, tx_done,
    output A, B, OP, tx_start, tx_data, busy, err_timeout, err_overrun
  );

  modport slave (
    output rx_done, rx_data, alu_result, tx_busy, tx_done,
    input  A, B, OP, tx_start, tx_data, busy, err_timeout, err_overrun
  );
endinterface

// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl
// Collects a three-byte frame from a UART receiver: operand A, operand B and the opcode.
// It presents them to an external combinational ALU, latches the result, and sends the
// result back through a UART transmitter.
// Ports:
//   clk       : system clock. All state changes happen on the rising edge.
//   btn_Reset : synchronous, active-high reset. It overrides everything else.
//   bus       : alu_uart_ctrl_if.master, carrying the rx/tx handshakes, ALU operands/result and status.
// The idle timeout aborts a half-received frame. Bytes that arrive while a frame is executing
// or being sent are dropped and reported through the sticky err_overrun flag.
module alu_uart_ctrl #(
  parameter int MAXTAM  = 8,
  parameter int tam_OP  = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic            clk,
  input  logic            btn_Reset,
  alu_uart_ctrl_if.master bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] IDLE_MAX  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] IDLE_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] IDLE_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t            state_q;
  logic [MAXTAM-1:0] a_q;
  logic [MAXTAM-1:0] b_q;
  logic [tam_OP-1:0] op_q;
  logic [MAXTAM-1:0] tx_data_q;
  logic              tx_start_q;
  logic              busy_q;
  logic              err_timeout_q;
  logic              err_overrun_q;
  logic [CW-1:0]     idle_q;
  logic [CW-1:0]     idle_d;
  logic              idle_expired_s;
  logic              in_frame_exec_s;

  assign idle_expired_s  = (idle_q == IDLE_MAX);
  assign idle_d          = idle_q + IDLE_ONE;
  // In these states the controller cannot accept a new byte.
  assign in_frame_exec_s = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);

  // Frame FSM. All outputs are registered and updated together with the state.
  always_ff @(posedge clk) begin
    if (btn_Reset) begin
      state_q       <= WAIT_A;
      a_q           <= {MAXTAM{1'b0}};
      b_q           <= {MAXTAM{1'b0}};
      op_q          <= {tam_OP{1'b0}};
      tx_data_q     <= {MAXTAM{1'b0}};
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      idle_q        <= IDLE_ZERO;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        WAIT_A: begin
          idle_q <= IDLE_ZERO;
          if (bus.rx_done) begin
            a_q           <= bus.rx_data;
            err_timeout_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= WAIT_B;
          end
        end
        WAIT_B: begin
          // An accepted byte takes priority over a timeout in the same cycle.
          if (bus.rx_done) begin
            b_q     <= bus.rx_data;
            idle_q  <= IDLE_ZERO;
            state_q <= WAIT_OP;
          end else if (idle_expired_s) begin
            idle_q        <= IDLE_ZERO;
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= WAIT_A;
          end else begin
            idle_q <= idle_d;
          end
        end
        WAIT_OP: begin
          if (bus.rx_done) begin
            op_q    <= bus.rx_data[tam_OP-1:0];
            idle_q  <= IDLE_ZERO;
            state_q <= EXEC;
          end else if (idle_expired_s) begin
            idle_q        <= IDLE_ZERO;
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= WAIT_A;
          end else begin
            idle_q <= idle_d;
          end
        end
        EXEC: begin
          // The ALU has had one full cycle with the new OP, so its result is stable here.
          tx_data_q <= bus.alu_result;
          state_q   <= SEND;
        end
        SEND: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            state_q    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (bus.tx_done) begin
            busy_q  <= 1'b0;
            state_q <= WAIT_A;
          end
        end
        default: begin
          idle_q  <= IDLE_ZERO;
          busy_q  <= 1'b0;
          state_q <= WAIT_A;
        end
      endcase
      if (bus.rx_done && in_frame_exec_s) begin
        err_overrun_q <= 1'b1;
      end
    end
  end

  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.OP          = op_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb_alu_uart_ctrl
// Directed bench for alu_uart_ctrl with TIMEOUT=16. The ALU is modelled as A + B.
// Inputs change 1 ns after each rising edge, and outputs are checked at that point too.
module tb_alu_uart_ctrl;

  logic clk;
  logic btn_Reset;
  int   tests;
  int   fails;

  alu_uart_ctrl_if #(.MAXTAM(8), .tam_OP(6)) bus ();

  alu_uart_ctrl #(.MAXTAM(8), .tam_OP(6), .TIMEOUT(16)) dut (
    .clk       (clk),
    .btn_Reset (btn_Reset),
    .bus       (bus)
  );

  assign bus.alu_result = bus.A + bus.B;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_A"}, bus.A, 32'd0);
    check({tag, "_B"}, bus.B, 32'd0);
    check({tag, "_OP"}, bus.OP, 32'd0);
    check({tag, "_txd"}, bus.tx_data, 32'd0);
    check({tag, "_txs"}, bus.tx_start, 32'd0);
    check({tag, "_busy"}, bus.busy, 32'd0);
    check({tag, "_eto"}, bus.err_timeout, 32'd0);
    check({tag, "_eov"}, bus.err_overrun, 32'd0);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    btn_Reset     = 1'b1;
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.tx_busy   = 1'b0;
    bus.tx_done   = 1'b0;
    step();
    step();
    btn_Reset = 1'b0;
    check_reset_values("rst");

    // Basic ADD frame: 50 + 30 = 80, tx_start two cycles after the OP byte.
    send_byte(8'd50);
    check("f1_A", bus.A, 32'd50);
    check("f1_busy", bus.busy, 32'd1);
    send_byte(8'd30);
    check("f1_B", bus.B, 32'd30);
    send_byte(8'h20);
    check("f1_OP", bus.OP, 32'h20);
    check("f1_txs_e0", bus.tx_start, 32'd0);
    step();
    check("f1_txd", bus.tx_data, 32'd80);
    check("f1_txs_e1", bus.tx_start, 32'd0);
    step();
    check("f1_txs_e2", bus.tx_start, 32'd1);
    step();
    check("f1_txs_e3", bus.tx_start, 32'd0);
    check("f1_busy_wtx", bus.busy, 32'd1);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("f1_busy_end", bus.busy, 32'd0);
    check("f1_A_hold", bus.A, 32'd50);
    check("f1_txd_hold", bus.tx_data, 32'd80);

    // Transmitter busy for 10 cycles after EXEC: the FSM holds in SEND and
    // then starts exactly once. A stray tx_done while in SEND is ignored.
    send_byte(8'd1);
    send_byte(8'd2);
    send_byte(8'd3);
    bus.tx_busy = 1'b1;
    step();
    check("f2_txd", bus.tx_data, 32'd3);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
      check("f2_txs_held", bus.tx_start, 32'd0);
    end
    check("f2_busy_send", bus.busy, 32'd1);
    bus.tx_busy = 1'b0;
    step();
    check("f2_txs_go", bus.tx_start, 32'd1);
    step();
    check("f2_txs_once", bus.tx_start, 32'd0);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("f2_busy_end", bus.busy, 32'd0);

    // Timeout after 16 idle cycles in WAIT_B.
    send_byte(8'h05);
    check("to_A", bus.A, 32'h05);
    repeat (15) step();
    check("to_busy_pre", bus.busy, 32'd1);
    check("to_eto_pre", bus.err_timeout, 32'd0);
    step();
    check("to_busy", bus.busy, 32'd0);
    check("to_eto", bus.err_timeout, 32'd1);
    check("to_A_hold", bus.A, 32'h05);
    send_byte(8'h07);
    check("to_A_new", bus.A, 32'h07);
    check("to_eto_clr", bus.err_timeout, 32'd0);

    // A byte arriving on the timeout cycle is accepted.
    repeat (15) step();
    send_byte(8'h09);
    check("tob_B", bus.B, 32'h09);
    check("tob_busy", bus.busy, 32'd1);
    check("tob_eto", bus.err_timeout, 32'd0);

    // Only the low 6 bits of the opcode byte are kept.
    send_byte(8'hFF);
    check("op_trunc", bus.OP, 32'h3F);
    step();
    check("f3_txd", bus.tx_data, 32'h10);
    step();
    check("f3_txs", bus.tx_start, 32'd1);

    // A byte arriving during WAIT_TX is dropped and raises err_overrun.
    send_byte(8'hAA);
    check("ov_flag", bus.err_overrun, 32'd1);
    check("ov_A", bus.A, 32'h07);
    check("ov_B", bus.B, 32'h09);
    check("ov_OP", bus.OP, 32'h3F);
    check("ov_txd", bus.tx_data, 32'h10);
    check("ov_busy", bus.busy, 32'd1);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("ov_busy_end", bus.busy, 32'd0);
    check("ov_sticky", bus.err_overrun, 32'd1);

    // Reset in WAIT_OP, together with rx_done.
    send_byte(8'h11);
    send_byte(8'h22);
    btn_Reset   = 1'b1;
    bus.rx_data = 8'h33;
    bus.rx_done = 1'b1;
    step();
    btn_Reset   = 1'b0;
    bus.rx_done = 1'b0;
    check_reset_values("rst_wop");

    // Reset in WAIT_TX, together with rx_done and tx_done.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h04);
    step();
    step();
    check("rwtx_txs", bus.tx_start, 32'd1);
    btn_Reset   = 1'b1;
    bus.rx_data = 8'h44;
    bus.rx_done = 1'b1;
    bus.tx_done = 1'b1;
    step();
    btn_Reset   = 1'b0;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    check_reset_values("rst_wtx");
    send_byte(8'h12);
    check("post_rst_A", bus.A, 32'h12);
    check("post_rst_busy", bus.busy, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_uart_ctrl.md
ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 Parameter MAXTAM, default 8: width of operands A, B, result and serial data bytes.
REQ-002 Parameter tam_OP, default 6: width of the ALU opcode.
REQ-003 Parameter TIMEOUT, default 1000000: maximum idle clock cycles allowed between bytes of one frame.
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 btn_Reset  in  1  synchronous, active-high reset.
REQ-006 rx_done  in  1  one-cycle pulse from the UART receiver; rx_data is valid in that cycle.
REQ-007 rx_data  in  MAXTAM  received byte.
REQ-008 alu_result  in  MAXTAM  combinational ALU output computed from A, B and OP.
REQ-009 tx_busy  in  1  UART transmitter busy; high while a byte is being sent.
REQ-010 tx_done  in  1  one-cycle pulse from the UART transmitter at the end of a byte.
REQ-011 A  out  MAXTAM  registered operand A to the ALU.
REQ-012 B  out  MAXTAM  registered operand B to the ALU.
REQ-013 OP  out  tam_OP  registered opcode to the ALU.
REQ-014 tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
REQ-015 tx_data  out  MAXTAM  registered result byte to the transmitter.
REQ-016 busy  out  1  high in every state except WAIT_A.
REQ-017 err_timeout  out  1  sticky flag; frame aborted on timeout.
REQ-018 err_overrun  out  1  sticky flag; rx_done received while a frame was being executed or sent.

Function
REQ-019 The FSM SHALL have six states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-020 WAIT_A + rx_done: A <= rx_data, go to WAIT_B, clear err_timeout.
REQ-021 WAIT_B + rx_done: B <= rx_data, go to WAIT_OP.
REQ-022 WAIT_OP + rx_done: OP <= rx_data[tam_OP-1:0] (upper bits discarded), go to EXEC.
REQ-023 EXEC: exactly one cycle; tx_data <= alu_result; go to SEND.
REQ-024 SEND: if tx_busy = 0, tx_start <= 1 and go to WAIT_TX; otherwise hold in SEND with tx_start = 0.
REQ-025 tx_start SHALL be high for exactly one cycle per frame.
REQ-026 With tx_busy low, tx_start SHALL be visible exactly 2 cycles after the edge that samples the OP byte.
REQ-027 WAIT_TX + tx_done: go to WAIT_A. A, B, OP and tx_data hold their values.
REQ-028 An idle counter SHALL clear on every accepted byte and on entry to WAIT_B, and SHALL increment each cycle in WAIT_B or WAIT_OP without rx_done.
REQ-029 Timeout: when the counter reaches TIMEOUT-1 with no rx_done, go to WAIT_A, set err_timeout, clear the counter; A/B/OP hold.
REQ-030 If rx_done coincides with the timeout cycle, the byte SHALL be accepted and no timeout SHALL occur.
REQ-031 rx_done in EXEC, SEND or WAIT_TX: byte dropped, err_overrun <= 1, state unaffected.
REQ-032 tx_done outside WAIT_TX SHALL be ignored.
REQ-033 A, B, OP and tx_data SHALL change only in the states defined above.

Reset
REQ-034 When btn_Reset = 1 at an edge, the block SHALL go to WAIT_A with A=0, B=0, OP=0, tx_data=0, tx_start=0, busy=0, err_timeout=0, err_overrun=0 and idle counter=0.
REQ-035 Reset SHALL dominate any simultaneous rx_done or tx_done and SHALL abort a frame in any state, including WAIT_TX with a transmission in flight.

Verification
REQ-036 Bytes 50, 30, 0x20 with the ALU modelled as ADD, tx_busy=0 -> A=50, B=30, OP=0x20; tx_data=80; a single tx_start two cycles after the OP byte; tx_done -> WAIT_A, busy=0.
REQ-037 Same frame with tx_busy held high for 10 cycles after EXEC -> remains in SEND; tx_start fires on the first cycle after tx_busy falls, exactly once.
REQ-038 TIMEOUT=16; byte 0x05 then no input -> after 16 idle cycles in WAIT_B, state WAIT_A, err_timeout=1; next byte 0x07 -> A=7, err_timeout=0.
REQ-039 Extra rx_done (0xAA) during WAIT_TX -> err_overrun=1; A/B/OP/tx_data unchanged; frame completes normally.
REQ-040 Reset asserted in WAIT_OP and again in WAIT_TX, each coincident with rx_done -> WAIT_A, all outputs at reset values, byte not captured.
REQ-041 Byte 0xFF in WAIT_OP with tam_OP=6 -> OP=0x3F.
